// File: rtl/delay_tap_select_if.sv
// Bundles the sample strobe, tap bus, delay configuration and
// delay-and-sum outputs of delay_tap_select.
interface delay_tap_select_if #(
    parameter int NTAPS = 43,
    parameter int W     = 14,
    parameter int DW    = 6
);
    logic                 shift_data_state;
    logic [NTAPS*W-1:0]   taps;
    logic                 cfg_wr;
    logic [1:0]           cfg_ch;
    logic [DW-1:0]        cfg_delay;
    logic                 cfg_commit;
    logic                 cfg_clr_err;
    logic [3:0]           ch_en;
    logic                 commit_pend;
    logic                 cfg_err;
    logic [4*W-1:0]       ch_out;
    logic [W+1:0]         sum_out;
    logic                 out_valid;

    modport master (
        output shift_data_state, taps, cfg_wr, cfg_ch, cfg_delay,
               cfg_commit, cfg_clr_err, ch_en,
        input  commit_pend, cfg_err, ch_out, sum_out, out_valid
    );

    modport slave (
        input  shift_data_state, taps, cfg_wr, cfg_ch, cfg_delay,
               cfg_commit, cfg_clr_err, ch_en,
        output commit_pend, cfg_err, ch_out, sum_out, out_valid
    );
endinterface

// File: rtl/delay_tap_select.sv
// Per-channel delayed tap selection from the shared sample shift register,
// with atomic shadow->active delay commit and a registered delay-and-sum.
module delay_tap_lane #(
    parameter int NTAPS = 43,
    parameter int W     = 14,
    parameter int DW    = 6
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NTAPS-1:0][W-1:0]    taps,
    input  logic [DW-1:0]              dly,
    input  logic                       en,
    input  logic                       ld_sel,
    input  logic                       ld_out,
    output logic [W-1:0]               sel,
    output logic [W-1:0]               out
);
    logic [W-1:0] tap_pick;

    // Delays are clamped on write, so the guard only covers unused codes.
    assign tap_pick = (dly < DW'(NTAPS)) ? taps[dly] : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel <= '0;
            out <= '0;
        end else begin
            if (ld_sel) sel <= en ? tap_pick : '0;
            if (ld_out) out <= sel;
        end
    end
endmodule

module delay_tap_select #(
    parameter int NTAPS = 43,
    parameter int W     = 14,
    parameter int DW    = 6
) (
    input  logic              clk,
    input  logic              rstn,
    delay_tap_select_if.slave bus
);
    localparam int            NCH    = 4;
    localparam int            STAGES = 2;
    localparam logic [DW-1:0] MAXD   = DW'(NTAPS - 1);

    logic [NCH-1:0][DW-1:0]   shadow, shadow_nxt, active;
    logic [NTAPS-1:0][W-1:0]  tap_arr;
    logic [NCH-1:0][W-1:0]    sel, ch_q;
    logic [STAGES:0]          vld_pipe;
    logic [W+1:0]             sum_nxt, sum_q;
    logic                     commit_pend, cfg_err;
    logic                     strobe, clamp, apply;
    logic [DW-1:0]            wr_val;

    assign tap_arr = bus.taps;
    assign strobe  = bus.shift_data_state;
    assign clamp   = bus.cfg_delay > MAXD;
    assign wr_val  = clamp ? MAXD : bus.cfg_delay;
    assign apply   = strobe & (commit_pend | bus.cfg_commit);

    // A write landing on the applying edge must reach the active set too.
    always_comb begin
        shadow_nxt = shadow;
        if (bus.cfg_wr) shadow_nxt[bus.cfg_ch] = wr_val;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow      <= '0;
            active      <= '0;
            commit_pend <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            if (apply) begin
                active      <= shadow_nxt;
                commit_pend <= 1'b0;
            end else if (bus.cfg_commit) begin
                commit_pend <= 1'b1;
            end
            if (bus.cfg_wr && clamp)  cfg_err <= 1'b1;
            else if (bus.cfg_clr_err) cfg_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[STAGES-1:0], strobe};
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        delay_tap_lane #(.NTAPS(NTAPS), .W(W), .DW(DW)) u_lane (
            .clk    (clk),
            .rstn   (rstn),
            .taps   (tap_arr),
            .dly    (active[i]),
            .en     (bus.ch_en[i]),
            .ld_sel (vld_pipe[0]),
            .ld_out (vld_pipe[1]),
            .sel    (sel[i]),
            .out    (ch_q[i])
        );
    end

    // Two guard bits make the four-way signed sum exact.
    always_comb begin
        sum_nxt = '0;
        for (int i = 0; i < NCH; i++)
            sum_nxt = sum_nxt + {{2{sel[i][W-1]}}, sel[i]};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)            sum_q <= '0;
        else if (vld_pipe[1]) sum_q <= sum_nxt;
    end

    assign bus.commit_pend = commit_pend;
    assign bus.cfg_err     = cfg_err;
    assign bus.ch_out      = ch_q;
    assign bus.sum_out     = sum_q;
    assign bus.out_valid   = vld_pipe[STAGES];
endmodule

// File: tb/tb_delay_tap_select.sv
// Table vectors, directed corner sequences and random traffic, all scored
// against a transaction-level model of the delay-and-sum path.
module tb_delay_tap_select;
    localparam int NTAPS = 43;
    localparam int W     = 14;
    localparam int DW    = 6;

    typedef struct {
        int due;
        int ch[4];
        int sum;
    } exp_t;

    typedef struct {
        int         pat;    // 0: tap k = k, 1: all taps = cval
        int         cval;
        int         dly[4];
        logic [3:0] en;
        int         ech[4];
        int         esum;
    } vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    delay_tap_select_if #(.NTAPS(NTAPS), .W(W), .DW(DW)) bus();

    delay_tap_select #(.NTAPS(NTAPS), .W(W), .DW(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   m_shadow[4];
    int   m_active[4];
    bit   m_pend, m_err, m_prev;
    exp_t held;
    exp_t q[$];
    vec_t vt[5];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int tap_val(input int k);
        logic [W-1:0] t;
        t = bus.taps[k*W +: W];
        return int'($signed(t));
    endfunction

    function automatic int ch_act(input int i);
        logic [W-1:0] t;
        t = bus.ch_out[i*W +: W];
        return int'($signed(t));
    endfunction

    function automatic int sum_act();
        return int'($signed(bus.sum_out));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
            held.ch[i]  = 0;
        end
        held.sum = 0;
        held.due = 0;
        m_pend   = 0;
        m_err    = 0;
        m_prev   = 0;
        q.delete();
    endtask

    task automatic clear_pulses();
        bus.shift_data_state = 1'b0;
        bus.cfg_wr           = 1'b0;
        bus.cfg_commit       = 1'b0;
        bus.cfg_clr_err      = 1'b0;
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (q.size() > 0) && (q[0].due == cyc);
        if (ev) begin
            held = q[0];
            void'(q.pop_front());
        end
        chk("out_valid", int'(bus.out_valid), int'(ev));
        for (int i = 0; i < 4; i++) chk($sformatf("ch_out[%0d]", i), ch_act(i), held.ch[i]);
        chk("sum_out", sum_act(), held.sum);
        chk("commit_pend", int'(bus.commit_pend), int'(m_pend));
        chk("cfg_err", int'(bus.cfg_err), int'(m_err));
    endtask

    // One clock edge: advance the model with the inputs now on the bus,
    // let the DUT clock, then score at the falling edge.
    task automatic tick();
        exp_t e;
        int   nsh[4];
        int   d;
        if (m_prev) begin
            e.sum = 0;
            for (int i = 0; i < 4; i++) begin
                e.ch[i] = bus.ch_en[i] ? tap_val(m_active[i]) : 0;
                e.sum  += e.ch[i];
            end
            e.due = cyc + 2;
            q.push_back(e);
        end
        m_prev = bus.shift_data_state;
        nsh    = m_shadow;
        d      = int'(bus.cfg_delay);
        if (bus.cfg_wr) nsh[bus.cfg_ch] = (d > NTAPS-1) ? NTAPS-1 : d;
        if (bus.cfg_wr && d > NTAPS-1) m_err = 1;
        else if (bus.cfg_clr_err)      m_err = 0;
        if (bus.shift_data_state && (m_pend || bus.cfg_commit)) begin
            m_active = nsh;
            m_pend   = 0;
        end else if (bus.cfg_commit) begin
            m_pend = 1;
        end
        m_shadow = nsh;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
        clear_pulses();
    endtask

    task automatic wr(input int ch, input int d);
        bus.cfg_wr    = 1'b1;
        bus.cfg_ch    = 2'(ch);
        bus.cfg_delay = DW'(d);
        tick();
    endtask

    task automatic strobe();
        bus.shift_data_state = 1'b1;
        tick();
    endtask

    task automatic set_ramp(input int off);
        for (int k = 0; k < NTAPS; k++) bus.taps[k*W +: W] = W'(k + off);
    endtask

    task automatic set_const(input int v);
        for (int k = 0; k < NTAPS; k++) bus.taps[k*W +: W] = W'(v);
    endtask

    task automatic set_rand();
        for (int k = 0; k < NTAPS; k++) bus.taps[k*W +: W] = W'($urandom);
    endtask

    // Asserted mid-cycle to exercise the asynchronous path.
    task automatic do_reset();
        #2;
        rstn = 1'b0;
        clear_pulses();
        model_reset();
        #1;
        chk("rst out_valid", int'(bus.out_valid), 0);
        chk("rst sum_out", sum_act(), 0);
        chk("rst ch_out", int'(bus.ch_out), 0);
        chk("rst commit_pend", int'(bus.commit_pend), 0);
        chk("rst cfg_err", int'(bus.cfg_err), 0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    function automatic vec_t mk(input int pat, input int cval,
                                input int d0, input int d1, input int d2, input int d3,
                                input logic [3:0] en,
                                input int e0, input int e1, input int e2, input int e3,
                                input int es);
        vec_t v;
        v.pat  = pat;
        v.cval = cval;
        v.dly  = '{d0, d1, d2, d3};
        v.en   = en;
        v.ech  = '{e0, e1, e2, e3};
        v.esum = es;
        return v;
    endfunction

    initial begin
        vt[0] = mk(0, 0,      0,  5, 17, 42, 4'hF,     0,     5,    17,    42,     64);
        vt[1] = mk(1, 8191,   1,  2,  3,  4, 4'hF,  8191,  8191,  8191,  8191,  32764);
        vt[2] = mk(1, -8192, 42,  0, 10, 20, 4'hF, -8192, -8192, -8192, -8192, -32768);
        vt[3] = mk(1, 100,    3,  3,  3,  3, 4'b0101, 100,    0,   100,     0,    200);
        vt[4] = mk(0, 0,     42, 42, 42, 42, 4'b1000,   0,     0,     0,    42,     42);

        bus.taps      = '0;
        bus.cfg_ch    = '0;
        bus.cfg_delay = '0;
        bus.ch_en     = 4'hF;
        clear_pulses();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        check_outputs();

        // zero taps: three strobes, pulses two edges after each
        for (int s = 0; s < 3; s++) begin
            strobe();
            tick();
            tick();
        end

        // table vectors
        for (int v = 0; v < 5; v++) begin
            if (vt[v].pat == 0) set_ramp(0);
            else                set_const(vt[v].cval);
            bus.ch_en = vt[v].en;
            for (int i = 0; i < 4; i++) wr(i, vt[v].dly[i]);
            bus.cfg_commit = 1'b1;
            strobe();
            tick();
            tick();
            chk($sformatf("vec%0d out_valid", v), int'(bus.out_valid), 1);
            for (int i = 0; i < 4; i++)
                chk($sformatf("vec%0d ch%0d", v, i), ch_act(i), vt[v].ech[i]);
            chk($sformatf("vec%0d sum", v), sum_act(), vt[v].esum);
            if (v == 2) chk("vec2 sum raw", int'(bus.sum_out), 32768);
            tick();
        end

        // shadow writes without commit leave outputs alone
        set_ramp(0);
        bus.ch_en = 4'hF;
        for (int i = 0; i < 4; i++) wr(i, i + 1);
        for (int s = 0; s < 4; s++) begin
            strobe();
            tick();
        end
        tick();
        tick();
        bus.cfg_commit = 1'b1;
        tick();
        chk("commit_pend held", int'(bus.commit_pend), 1);
        tick();
        chk("commit_pend idle", int'(bus.commit_pend), 1);
        strobe();
        chk("commit_pend cleared", int'(bus.commit_pend), 0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) chk($sformatf("switch ch%0d", i), ch_act(i), i + 1);
        chk("switch sum", sum_act(), 10);

        // clamping write and sticky error
        wr(2, 50);
        chk("clamp err", int'(bus.cfg_err), 1);
        bus.cfg_clr_err = 1'b1;
        wr(1, 60);
        chk("set beats clr", int'(bus.cfg_err), 1);
        bus.cfg_clr_err = 1'b1;
        tick();
        chk("lone clr", int'(bus.cfg_err), 0);
        // write on the applying edge lands in active as well
        bus.cfg_commit = 1'b1;
        bus.cfg_wr     = 1'b1;
        bus.cfg_ch     = 2'd0;
        bus.cfg_delay  = 6'd7;
        strobe();
        tick();
        tick();
        chk("clamped ch2", ch_act(2), 42);
        chk("clamped ch1", ch_act(1), 42);
        chk("same-edge wr ch0", ch_act(0), 7);
        chk("commit+apply pend", int'(bus.commit_pend), 0);

        // five back-to-back strobes with fresh taps each cycle
        for (int s = 0; s < 5; s++) begin
            set_rand();
            bus.shift_data_state = 1'b1;
            tick();
        end
        for (int s = 0; s < 4; s++) tick();

        // reset with samples in flight
        set_ramp(1);
        for (int s = 0; s < 3; s++) strobe();
        do_reset();
        tick();
        tick();
        tick();
        strobe();
        tick();
        chk("post-rst early valid", int'(bus.out_valid), 0);
        tick();
        chk("post-rst valid", int'(bus.out_valid), 1);
        for (int i = 0; i < 4; i++) chk($sformatf("post-rst ch%0d", i), ch_act(i), 1);
        chk("post-rst sum", sum_act(), 4);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) set_rand();
            if ($urandom_range(0, 15) == 0) bus.ch_en = 4'($urandom);
            bus.shift_data_state = 1'($urandom_range(0, 1));
            bus.cfg_wr           = ($urandom_range(0, 3) == 0);
            bus.cfg_ch           = 2'($urandom);
            bus.cfg_delay        = DW'($urandom_range(0, 63));
            bus.cfg_commit       = ($urandom_range(0, 7) == 0);
            bus.cfg_clr_err      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 399) == 0) do_reset();
            else                             tick();
        end
        for (int s = 0; s < 4; s++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
